// File: rtl/button_pkg.sv
// Shared types for the button gesture decoder.
package button_pkg;

   typedef enum logic [2:0] {
      BE_IDLE,
      BE_PRESS1,
      BE_LONG,
      BE_WAIT2,
      BE_PRESS2
   } be_state_t;

   // One-cycle gesture events, bundled for top-level use.
   // The falling-edge event is called "released" because "release" is a reserved word.
   typedef struct packed {
      logic press;
      logic released;
      logic click;
      logic dclick;
      logic long_press;
   } button_evt_t;

endpackage

// File: rtl/button_events_if.sv
// Button level in, gesture event pulses out.
interface button_events_if;

   logic btn;
   logic held;
   logic press;
   logic released;
   logic click;
   logic dclick;
   logic long_press;

   modport master (
      output btn,
      input  held, press, released, click, dclick, long_press
   );

   modport slave (
      input  btn,
      output held, press, released, click, dclick, long_press
   );

endinterface

// File: rtl/edge_detect.sv
// Registers a synchronous level and reports its rising and falling edges.
module edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   // Reset loads the live input, so a level held through reset gives no edge.
   always_ff @(posedge clk) begin
      if (rst) q <= d;
      else     q <= d;
   end

   assign rise = d & ~q;
   assign fall = ~d & q;

endmodule

// File: rtl/button_events.sv
// Gesture decoder: press/release edges, single click, double click and long press.
import button_pkg::*;

module button_events #(
   parameter logic [23:0] LONG_CYCLES = 24'd12_000_000,
   parameter logic [23:0] GAP_CYCLES  = 24'd6_000_000
) (
   input  logic           clk,
   input  logic           rst,
   button_events_if.slave bus
);

   localparam int unsigned MAX_CYCLES = (LONG_CYCLES > GAP_CYCLES) ? int'(LONG_CYCLES) : int'(GAP_CYCLES);
   localparam int unsigned TW         = $clog2(MAX_CYCLES) + 1;
   localparam logic [TW-1:0] LONG_TC  = TW'(LONG_CYCLES - 24'd1);
   localparam logic [TW-1:0] GAP_TC   = TW'(GAP_CYCLES - 24'd1);

   logic        btn_q;
   logic        rise;
   logic        fall;
   be_state_t   state;
   logic [TW-1:0] timer;
   button_evt_t evt;

   edge_detect u_edge (
      .clk  (clk),
      .rst  (rst),
      .d    (bus.btn),
      .q    (btn_q),
      .rise (rise),
      .fall (fall)
   );

   // Gesture FSM with shared timer and registered event pulses.
   // Edges are tested before the terminal count so an edge wins a tie;
   // any state change overrides the default timer increment with a clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= BE_IDLE;
         timer <= '0;
         evt   <= '0;
      end else begin
         evt.press      <= rise;
         evt.released   <= fall;
         evt.click      <= 1'b0;
         evt.dclick     <= 1'b0;
         evt.long_press <= 1'b0;
         if (timer != '1) timer <= timer + 1'b1;
         unique case (state)
            BE_IDLE: begin
               if (rise) begin
                  state <= BE_PRESS1;
                  timer <= '0;
               end
            end
            BE_PRESS1: begin
               if (fall) begin
                  state <= BE_WAIT2;
                  timer <= '0;
               end else if (timer == LONG_TC) begin
                  evt.long_press <= 1'b1;
                  state          <= BE_LONG;
                  timer          <= '0;
               end
            end
            BE_LONG: begin
               if (fall) begin
                  state <= BE_IDLE;
                  timer <= '0;
               end
            end
            BE_WAIT2: begin
               if (rise) begin
                  state <= BE_PRESS2;
                  timer <= '0;
               end else if (timer == GAP_TC) begin
                  evt.click <= 1'b1;
                  state     <= BE_IDLE;
                  timer     <= '0;
               end
            end
            BE_PRESS2: begin
               if (fall) begin
                  evt.dclick <= 1'b1;
                  state      <= BE_IDLE;
                  timer      <= '0;
               end else if (timer == LONG_TC) begin
                  evt.long_press <= 1'b1;
                  state          <= BE_LONG;
                  timer          <= '0;
               end
            end
            default: begin
               state <= BE_IDLE;
               timer <= '0;
            end
         endcase
      end
   end

   assign bus.held       = btn_q;
   assign bus.press      = evt.press;
   assign bus.released   = evt.released;
   assign bus.click      = evt.click;
   assign bus.dclick     = evt.dclick;
   assign bus.long_press = evt.long_press;

endmodule

// File: tb/tb_button_events.sv
// Randomized bench for button_events against a deadline-based gesture model.
module tb_button_events;

   localparam int LONG = 20;
   localparam int GAP  = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;

   button_events_if bus();

   button_events #(
      .LONG_CYCLES (24'd20),
      .GAP_CYCLES  (24'd10)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: a gesture is tracked by the edge index at which each
   // pending event is due, rather than by a running counter.
   typedef enum int {G_NONE, G_FIRST_DOWN, G_HELD_LONG, G_GAP, G_SECOND_DOWN} gesture_t;
   gesture_t g = G_NONE;
   int  k = 0;
   int  long_due = 0;
   int  click_due = 0;
   logic bprev = 1'b0;
   logic e_held = 1'b0, e_press = 1'b0, e_rel = 1'b0, e_click = 1'b0, e_dclick = 1'b0, e_long = 1'b0;
   bit  armed = 1'b0;

   always @(posedge clk) begin
      logic b;
      logic up, down;
      b = bus.btn;
      e_press = 1'b0; e_rel = 1'b0; e_click = 1'b0; e_dclick = 1'b0; e_long = 1'b0;
      e_held = b;
      if (rst) begin
         g = G_NONE;
         bprev = b;
      end else begin
         up   = b && !bprev;
         down = !b && bprev;
         e_press = up;
         e_rel   = down;
         case (g)
            G_NONE:       if (up) begin g = G_FIRST_DOWN; long_due = k + LONG; end
            G_FIRST_DOWN: if (down) begin g = G_GAP; click_due = k + GAP; end
                          else if (k == long_due) begin e_long = 1'b1; g = G_HELD_LONG; end
            G_HELD_LONG:  if (down) g = G_NONE;
            G_GAP:        if (up) begin g = G_SECOND_DOWN; long_due = k + LONG; end
                          else if (k == click_due) begin e_click = 1'b1; g = G_NONE; end
            G_SECOND_DOWN: if (down) begin e_dclick = 1'b1; g = G_NONE; end
                          else if (k == long_due) begin e_long = 1'b1; g = G_HELD_LONG; end
            default: g = G_NONE;
         endcase
         bprev = b;
      end
      k++;
      armed = 1'b1;
   end

   int n_press = 0, n_rel = 0, n_click = 0, n_dclick = 0, n_long = 0;

   // Per-cycle comparison away from the active edge, plus pulse tallies.
   always @(negedge clk) begin
      if (armed) begin
         check("held",       32'(bus.held),       32'(e_held));
         check("press",      32'(bus.press),      32'(e_press));
         check("release",    32'(bus.released),   32'(e_rel));
         check("click",      32'(bus.click),      32'(e_click));
         check("dclick",     32'(bus.dclick),     32'(e_dclick));
         check("long_press", 32'(bus.long_press), 32'(e_long));
         n_press  += int'(bus.press);
         n_rel    += int'(bus.released);
         n_click  += int'(bus.click);
         n_dclick += int'(bus.dclick);
         n_long   += int'(bus.long_press);
      end
   end

   task automatic drive(input logic b, input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         bus.btn = b;
         @(posedge clk);
         #1;
      end
   endtask

   int s_press, s_rel, s_click, s_dclick, s_long;

   task automatic snap();
      s_press = n_press; s_rel = n_rel; s_click = n_click; s_dclick = n_dclick; s_long = n_long;
   endtask

   task automatic expect_counts(input string tag, input int p, input int r, input int c, input int d, input int l);
      check({tag, ".press"},   32'(n_press - s_press),   32'(p));
      check({tag, ".release"}, 32'(n_rel - s_rel),       32'(r));
      check({tag, ".click"},   32'(n_click - s_click),   32'(c));
      check({tag, ".dclick"},  32'(n_dclick - s_dclick), 32'(d));
      check({tag, ".long"},    32'(n_long - s_long),     32'(l));
   endtask

   initial begin
      logic lvl;
      bus.btn = 1'b0;
      rst = 1'b1;
      drive(1'b0, 3);
      rst = 1'b0;
      drive(1'b0, 5);

      // Short press then click after the gap.
      snap(); drive(1'b1, 5); drive(1'b0, 15);
      expect_counts("single", 1, 1, 1, 0, 0);

      // Double click.
      snap(); drive(1'b1, 5); drive(1'b0, 4); drive(1'b1, 5); drive(1'b0, 15);
      expect_counts("double", 2, 2, 0, 1, 0);

      // Long hold.
      snap(); drive(1'b1, 30); drive(1'b0, 15);
      expect_counts("long", 1, 1, 0, 0, 1);

      // Release on the terminal count of the first press.
      snap(); drive(1'b1, LONG); drive(1'b0, 15);
      expect_counts("edge_long", 1, 1, 1, 0, 0);

      // Second press on the terminal count of the gap.
      snap(); drive(1'b1, 5); drive(1'b0, GAP); drive(1'b1, 5); drive(1'b0, 15);
      expect_counts("edge_gap", 2, 2, 0, 1, 0);

      // Button held through reset.
      drive(1'b1, 3);
      rst = 1'b1; drive(1'b1, 3); rst = 1'b0;
      snap(); drive(1'b1, 4); drive(1'b0, 15);
      expect_counts("rst_held", 0, 1, 0, 0, 0);

      // Reset during the gap abandons the gesture.
      drive(1'b1, 5); drive(1'b0, 3);
      rst = 1'b1; drive(1'b0, 1); rst = 1'b0;
      snap(); drive(1'b0, 15);
      expect_counts("rst_gap", 0, 0, 0, 0, 0);
      snap(); drive(1'b1, 5); drive(1'b0, 15);
      expect_counts("after_rst", 1, 1, 1, 0, 0);

      // Random gestures with occasional resets.
      lvl = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            rst = 1'b1;
            drive(1'($urandom_range(0, 1)), $urandom_range(1, 3));
            rst = 1'b0;
         end else begin
            lvl = ~lvl;
            drive(lvl, $urandom_range(1, 25));
         end
      end
      drive(1'b0, 40);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/button_events.md
# button_events

Gesture decoder that sits directly downstream of the button debouncer and upstream of user logic such as the LED counter. It consumes one debounced, active-high button level and produces single-cycle event pulses: press, release, single click, double click and long press. These replace ad-hoc `btn != btn_last` edge logic in top-level designs. All outputs are registered.

## Interface

- `LONG_CYCLES`, default 24'd12_000_000: cycles held before `long_press` fires; minimum 2.
- `GAP_CYCLES`, default 24'd6_000_000: maximum release-to-press gap, in cycles, that still counts as a double click; minimum 2.
- `clk`  in  1: system clock, single domain. Reset is synchronous and active-high.
- `rst`  in  1: synchronous reset, active-high.
- `btn`  in  1: debounced button level, 1 = pressed. Must already be synchronous to `clk`.
- `held`  out  1: registered copy of `btn`.
- `press`  out  1: one-cycle pulse on each rising edge of `btn`.
- `release`  out  1: one-cycle pulse on each falling edge of `btn`.
- `click`  out  1: one-cycle pulse for a completed single short click.
- `dclick`  out  1: one-cycle pulse for a completed double click.
- `long_press`  out  1: one-cycle pulse when the hold threshold is reached.

## Operation

- Edge detection:
  - `btn_q` samples `btn` every cycle.
  - rise = `btn & !btn_q`; fall = `!btn & btn_q`.
  - `press` and `release` are registered copies of rise and fall.
- Timer:
  - Single up-counter, cleared to 0 on every state change.
  - Increments by 1 otherwise and saturates at all-ones.
  - Width is `$clog2(max(LONG_CYCLES, GAP_CYCLES)) + 1`.
- FSM states: IDLE, PRESS1, LONG, WAIT2, PRESS2.
  - IDLE: on rise, go to PRESS1. A fall in IDLE is ignored.
  - PRESS1:
    - fall: go to WAIT2.
    - else, if timer == LONG_CYCLES-1: pulse `long_press` and go to LONG.
  - LONG: on fall, go to IDLE. No click event is generated.
  - WAIT2:
    - rise: go to PRESS2.
    - else, if timer == GAP_CYCLES-1: pulse `click` and go to IDLE.
  - PRESS2:
    - fall: pulse `dclick` and go to IDLE.
    - else, if timer == LONG_CYCLES-1: pulse `long_press` and go to LONG. The pending click is discarded; no `click` or `dclick` follows.
- Exactly one of `click`, `dclick` or `long_press` fires per gesture.
- Simultaneous events: an edge always beats a timeout in the same cycle.
  - PRESS1: a fall on the terminal count gives a short press, not a long press.
  - WAIT2: a rise on the terminal count gives PRESS2, not `click`.
- Reset (`rst` = 1):
  - State returns to IDLE and the timer clears.
  - All pulse outputs are 0.
  - `btn_q` and `held` load the current `btn` value, not 0. A button held through reset therefore produces no `press` on reset release, and its later fall is ignored in IDLE. `release` still pulses for that fall.
- Reset mid-gesture abandons the gesture; no event fires for it.

## Timing

- Latency: `btn` first sampled high at edge N gives `press` = 1 during cycle N+1. The same applies to `release` on a fall.
- `long_press`: asserted exactly LONG_CYCLES cycles after the `press` cycle of the triggering press, provided `btn` stays high.
- `click`: asserted exactly GAP_CYCLES cycles after the `release` cycle, provided no new press arrives.
- `dclick`: asserted in the same cycle as the second `release`.
- Pulses are exactly one cycle wide. Back-to-back gestures are fully supported.
- Outputs are 0 in the first cycle after reset deasserts. `held` equals `btn` from the previous edge.

## Structure

- Shared package `button_pkg` holds:
  - `typedef enum logic [2:0] {BE_IDLE, BE_PRESS1, BE_LONG, BE_WAIT2, BE_PRESS2} be_state_t`
  - the event-struct typedef `button_evt_t` {press, release, click, dclick, long_press}, for top-level bundling.
- One sub-module, `edge_detect`: registers its input and provides `q`, `rise` and `fall`. Its reset loads the input value.
- Timer and FSM live in `button_events` itself.

## Test plan

All scenarios use LONG_CYCLES=20 and GAP_CYCLES=10.

- Hold `btn` high 5 cycles, then low:
  - `press` and `release` pulse once each.
  - `click` fires 10 cycles after `release`.
  - `dclick` and `long_press` stay 0.
- Press 5 cycles, release 4 cycles, press 5 cycles, release:
  - `dclick` fires in the second `release` cycle.
  - `click` never fires.
- Hold `btn` high 30 cycles:
  - `long_press` fires 20 cycles after `press`.
  - On release, no `click` and no `dclick`.
- Boundary cases:
  - Release exactly on the cycle the timer hits 19 in PRESS1: `click`, not `long_press`.
  - Second press exactly at gap count 9: `dclick` path; `click` stays 0.
- Hold `btn` high, pulse `rst` for 3 cycles, release reset, then drop `btn`:
  - No `press` after reset.
  - `release` pulses once.
  - No `click` or `long_press`.
- Assert `rst` for 1 cycle during WAIT2:
  - All outputs 0.
  - No `click` ever fires for the abandoned gesture.
  - The next full press/release yields a normal `click`.
